// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard stall/flush controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    MD_WAIT = 2'd2
  } hz_state_t;

  localparam int unsigned LOAD_LAT_MAX = 7;
  localparam int unsigned MD_LAT_MAX   = 63;
  localparam int unsigned LD_CNT_W     = $clog2(LOAD_LAT_MAX + 1);
  localparam int unsigned MD_CNT_W     = $clog2(MD_LAT_MAX + 1);

  // Instruction word the ID/EX register loads when idex_bubble is asserted (sll $0,$0,0).
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

endpackage

// File: rtl/hazard_md_tracker.sv
// Mult/div occupancy counter: reloads on issue, counts down to idle.
module hazard_md_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_issue_i,
  output logic md_busy_o
);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_issue_i) begin
      md_cnt_d = MD_CNT_W'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / mult-div stall and EX branch flush controller for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds saturating stall_cycles and flush_count outputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MD_LAT   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_mem_to_reg,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ifid_md_start,
  input  logic             ifid_md_read,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count
`endif
);

  hz_state_t           state_q, state_d;
  logic [LD_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic                ld_hit, md_hazard, stall;

  assign ld_hit = idex_mem_to_reg && (idex_rd != '0) &&
                  ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));
  assign md_hazard = md_busy && (ifid_md_read || ifid_md_start);

  // Next state, counter and raw stall; a taken branch overrides everything.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        stall = ld_hit || md_hazard;
        if (ld_hit && (LOAD_LAT > 1)) begin
          state_d  = LD_WAIT;
          ld_cnt_d = LD_CNT_W'(LOAD_LAT - 1);
        end else if (md_hazard) begin
          state_d = MD_WAIT;
        end
      end
      LD_WAIT: begin
        stall    = 1'b1;
        ld_cnt_d = ld_cnt_q - LD_CNT_W'(1);
        if (ld_cnt_q <= LD_CNT_W'(1)) begin
          ld_cnt_d = '0;
          state_d  = md_hazard ? MD_WAIT : IDLE;
        end
      end
      MD_WAIT: begin
        stall = md_hazard;
        if (!md_hazard) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        ld_cnt_d = '0;
      end
    endcase
    if (ex_branch_taken) begin
      state_d  = IDLE;
      ld_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  assign pc_stall    = stall && !ex_branch_taken;
  assign ifid_stall  = stall && !ex_branch_taken;
  assign idex_bubble = stall || ex_branch_taken;
  assign ifid_flush  = ex_branch_taken;

  hazard_md_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_issue_i (ifid_md_start && !stall && !ex_branch_taken),
    .md_busy_o  (md_busy)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (pc_stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'(1);
      end
      if (ifid_flush && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 16'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench: instance A uses LOAD_LAT=1, instance B LOAD_LAT=3; both MD_LAT=4.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mtr, urt, mds, mdr, br;
  logic [4:0] rd, rs, rt;

  logic a_pcs, a_ifs, a_bub, a_fl, a_busy;
  logic b_pcs, b_ifs, b_bub, b_fl, b_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_sc, b_sc;
  logic [15:0] a_fc, b_fc;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .MD_LAT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .idex_mem_to_reg(mtr), .idex_rd(rd), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_uses_rt(urt), .ifid_md_start(mds), .ifid_md_read(mdr),
    .ex_branch_taken(br), .pc_stall(a_pcs), .ifid_stall(a_ifs), .idex_bubble(a_bub),
    .ifid_flush(a_fl), .md_busy(a_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(a_sc), .flush_count(a_fc)
`endif
  );

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .MD_LAT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .idex_mem_to_reg(mtr), .idex_rd(rd), .ifid_rs(rs),
    .ifid_rt(rt), .ifid_uses_rt(urt), .ifid_md_start(mds), .ifid_md_read(mdr),
    .ex_branch_taken(br), .pc_stall(b_pcs), .ifid_stall(b_ifs), .idex_bubble(b_bub),
    .ifid_flush(b_fl), .md_busy(b_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(b_sc), .flush_count(b_fc)
`endif
  );

  wire [4:0] a_vec = {a_pcs, a_ifs, a_bub, a_fl, a_busy};
  wire [4:0] b_vec = {b_pcs, b_ifs, b_bub, b_fl, b_busy};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, check {pc_stall,ifid_stall,idex_bubble,ifid_flush,md_busy} at negedge.
  task automatic apply(input string tag, input logic i_mtr, input logic [4:0] i_rd,
                       input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_urt,
                       input logic i_mds, input logic i_mdr, input logic i_br,
                       input logic [4:0] exp_a, input logic [4:0] exp_b);
    mtr = i_mtr; rd = i_rd; rs = i_rs; rt = i_rt; urt = i_urt;
    mds = i_mds; mdr = i_mdr; br = i_br;
    @(negedge clk);
    check({tag, "_a"}, 32'(a_vec), 32'(exp_a));
    check({tag, "_b"}, 32'(b_vec), 32'(exp_b));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mtr = 0; urt = 0; mds = 0; mdr = 0; br = 0; rd = 0; rs = 0; rt = 0;
    #12;
    check("rst_a", 32'(a_vec), 32'h0);
    check("rst_b", 32'(b_vec), 32'h0);
`ifdef HAZARD_PERF_EN
    check("rst_perf", {b_sc[15:0], b_fc}, 32'h0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // load-use via rs: A stalls 1 cycle, B stalls 3
    apply("lu_rs0", 1, 8, 8, 0, 0, 0, 0, 0, 5'b11100, 5'b11100);
    apply("lu_rs1", 0, 0, 8, 0, 0, 0, 0, 0, 5'b00000, 5'b11100);
    apply("lu_rs2", 0, 0, 8, 0, 0, 0, 0, 0, 5'b00000, 5'b11100);
    apply("lu_rs3", 0, 0, 8, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
    // load-use via rt with uses_rt set, then clear
    apply("lu_rt0", 1, 9, 0, 9, 1, 0, 0, 0, 5'b11100, 5'b11100);
    apply("lu_rt1", 0, 0, 0, 9, 1, 0, 0, 0, 5'b00000, 5'b11100);
    apply("lu_rt2", 0, 0, 0, 9, 1, 0, 0, 0, 5'b00000, 5'b11100);
    apply("lu_rt3", 0, 0, 0, 9, 1, 0, 0, 0, 5'b00000, 5'b00000);
    apply("rt_nouse", 1, 9, 0, 9, 0, 0, 0, 0, 5'b00000, 5'b00000);
    apply("rd_zero", 1, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 5'b00000);
    // mult then mflo: busy and stalled for 4 cycles
    apply("mult", 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000);
    apply("mflo1", 0, 0, 0, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("mflo2", 0, 0, 0, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("mflo3", 0, 0, 0, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("mflo4", 0, 0, 0, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("mflo_go", 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000);
    apply("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
    // branch in second stall cycle of B's load-use
    apply("fl_hit", 1, 8, 8, 0, 0, 0, 0, 0, 5'b11100, 5'b11100);
    apply("fl_br", 0, 0, 8, 0, 0, 0, 0, 1, 5'b00110, 5'b00110);
    apply("fl_after", 0, 0, 8, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);
    // flush does not clear an in-flight mult
    apply("mult2", 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000);
    apply("br_md", 0, 0, 0, 0, 0, 0, 0, 1, 5'b00111, 5'b00111);
    apply("md_br1", 0, 0, 0, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("md_br2", 0, 0, 0, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("md_br3", 0, 0, 0, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("md_br4", 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000);
    // simultaneous load-use and MD hazard: stall lasts max(LOAD_LAT, remaining md)
    apply("mult3", 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000);
    apply("ldmd0", 1, 8, 8, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("ldmd1", 0, 0, 8, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("ldmd2", 0, 0, 8, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("ldmd3", 0, 0, 8, 0, 0, 0, 1, 0, 5'b11101, 5'b11101);
    apply("ldmd4", 0, 0, 8, 0, 0, 0, 1, 0, 5'b00000, 5'b00000);
    apply("idle1", 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000);

    // asynchronous reset in the middle of an MD stall
    apply("mult4", 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000);
    mds = 0; mdr = 1;
    #2;
    check("pre_rst_a", 32'(a_vec), 32'h1d);
    check("pre_rst_b", 32'(b_vec), 32'h1d);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", 32'(a_vec), 32'h0);
    check("mid_rst_b", 32'(b_vec), 32'h0);
`ifdef HAZARD_PERF_EN
    check("mid_rst_perf", {b_sc[15:0], b_fc}, 32'h0);
`endif
    @(negedge clk);
    mdr = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply("post_rst", 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised stall/flush controller for the 5-stage forwarding pipeline. It is the successor to the single-cycle load-use detector.
- Adds configurable load-to-use latency, tracking of the multi-cycle multiply/divide unit, and EX-stage branch flush with defined priority.
- Sits between the ID-stage decoder and the PC, IF/ID and ID/EX pipeline registers; drives their stall, flush and bubble controls.

## Interface
Parameters:
- REG_W, 5, register-index width
- LOAD_LAT, 1, stall cycles a load-use dependency costs (1..7)
- MD_LAT, 32, cycles the mult/div unit is busy after issue (2..63)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- idex_mem_to_reg  in  1  instruction in ID/EX is a load
- idex_rd  in  REG_W  destination of the instruction in ID/EX
- ifid_rs  in  REG_W  first source of the instruction in IF/ID
- ifid_rt  in  REG_W  second source of the instruction in IF/ID
- ifid_uses_rt  in  1  rt is a real source (not a destination-only rt)
- ifid_md_start  in  1  ID instruction is mult/multu/div/divu
- ifid_md_read  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idex_bubble  out  1  load NOP into ID/EX
- ifid_flush  out  1  clear IF/ID
- md_busy  out  1  mult/div unit occupied

## Operation
- Load-use hit: idex_mem_to_reg && idex_rd != 0 && (idex_rd == ifid_rs || (ifid_uses_rt && idex_rd == ifid_rt)).
- FSM states: IDLE, LD_WAIT, MD_WAIT.
- IDLE:
  - Load-use hit -> stall this cycle.
  - If LOAD_LAT > 1, go to LD_WAIT with ld_cnt = LOAD_LAT-1.
- LD_WAIT:
  - Stall every cycle; ld_cnt decrements each cycle.
  - Exit to IDLE in the cycle ld_cnt reaches 1; the stall is still asserted in that cycle.
  - New detections are ignored here: the load has left ID/EX.
- MD tracking (independent counter md_cnt, 6 bits):
  - Loads MD_LAT when ifid_md_start && !stall && !ifid_flush, i.e. the op leaves ID.
  - Decrements to 0; md_busy = (md_cnt != 0).
- MD hazard: md_busy && (ifid_md_read || ifid_md_start).
  - IDLE -> MD_WAIT; stall until md_cnt reaches 0, then IDLE in the same cycle the stall drops.
- stall = load-use hit (IDLE) | LD_WAIT | MD hazard.
  - stall drives pc_stall = ifid_stall = idex_bubble = 1.
- Branch flush: ex_branch_taken -> ifid_flush = 1, idex_bubble = 1, pc_stall = ifid_stall = 0.
  - Flush overrides every stall; FSM forces IDLE and ld_cnt = 0.
  - md_cnt is NOT cleared: the issued mult/div is already in flight.
- Load-use and MD hazard in the same cycle: stall length is the maximum of the two. MD_WAIT is entered after LD_WAIT if md_busy is still set.

## Timing
- Detection is combinational: the stall appears in the same cycle as the hit, zero latency.
- FSM, ld_cnt and md_cnt are registered on posedge clk.
- Total stall for one load-use = LOAD_LAT cycles; for an MD hazard = remaining md_cnt cycles.
- Reset (rst_n low, async): state IDLE, ld_cnt = 0, md_cnt = 0.
  - With reset held and inputs idle, all outputs are 0.
  - Reset mid-stall releases the stall immediately.
- One-cycle stall windows never chain unless a new hit is present after the bubble.

## Configuration
- HAZARD_PERF_EN defined: adds output stall_cycles (32 bits) and output flush_count (16 bits).
  - Both reset to 0; they increment on stall and ifid_flush cycles respectively and saturate at all-ones.
- Undefined: neither port nor register exists; functional behaviour is identical.

## Structure
- Package hazard_pkg:
  - State enum (IDLE, LD_WAIT, MD_WAIT).
  - Counter width constants derived from LOAD_LAT/MD_LAT via $clog2.
  - NOP-insertion encoding shared with the ID/EX register.
- Sub-module hazard_md_tracker: md_cnt load/decrement and md_busy; instantiated once.

## Test plan
- LOAD_LAT=1, lw $t0 then add using $t0 as rs -> exactly 1 cycle of pc_stall/ifid_stall/idex_bubble, then clean advance.
- LOAD_LAT=3, lw $t1 then sw whose rt=$t1 with ifid_uses_rt=1 -> 3 stall cycles. Same with ifid_uses_rt=0 -> no stall.
- lw $zero then use $zero -> no stall.
- MD_LAT=4, mult then mflo on the next cycle -> md_busy for 4 cycles, mflo stalled 4 cycles, released when md_cnt hits 0.
- LOAD_LAT=3, hit, then ex_branch_taken in the 2nd stall cycle -> ifid_flush=1, idex_bubble=1, stall dropped, state IDLE next cycle.
- rst_n pulsed low during an MD_WAIT stall -> all outputs 0 asynchronously, md_busy=0; with HAZARD_PERF_EN, counters read 0.
